// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path.
// Provides the receiver state enum and the oversampling constants used to
// place sample points inside each bit cell.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int unsigned TICKS_PER_BIT = 16;
    localparam int unsigned SMP_W         = $clog2(TICKS_PER_BIT);

    // Sample offsets within a bit cell, counted in baud ticks.
    localparam logic [SMP_W-1:0] START_SAMPLE = SMP_W'(7);
    localparam logic [SMP_W-1:0] MID_SAMPLE   = SMP_W'(15);

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer: a chain of SYNC_STAGES flops, all reset to 1
// so an idle-high serial line does not look like a start bit after reset.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   d        asynchronous input
//   q        synchronized output
module uart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive stage: oversamples rx on the x16 baud enable, qualifies the
// start bit, shifts in 7/8 data bits LSB-first, checks optional parity and
// the stop bit, and holds one byte plus sticky error flags for the consumer.
// Ports:
//   clk, reset_n           clock and asynchronous active-low reset
//   baud_clock             x16 baud tick enable
//   rx                     asynchronous serial input (idle high)
//   bit8, parity_en,
//   odd_n_even             frame format controls
//   read_rx_byte           consumer pop; clears ready and all flags
//   rx_byte, rx_ready      held byte and its valid flag
//   parity_err,
//   framing_err, overflow  sticky status flags for the held byte
module uart_rx_deserializer
    import uart_rx_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       baud_clock,
    input  logic       rx,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic       read_rx_byte,
    output logic [7:0] rx_byte,
    output logic       rx_ready,
    output logic       parity_err,
    output logic       framing_err,
    output logic       overflow
);

    logic rx_s;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .d      (rx),
        .q      (rx_s)
    );

    rx_state_t        state_q, state_d;
    logic [SMP_W-1:0] smp_cnt_q, smp_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_acc_q, par_acc_d;
    logic             par_err_q, par_err_d;
    logic             frame_done;
    logic [2:0]       last_bit;
    logic [7:0]       rx_word;

    logic [7:0] rx_byte_q;
    logic       rx_ready_q, parity_err_q, framing_err_q, overflow_q;

    assign last_bit = bit8 ? 3'd7 : 3'd6;
    // Bits are shifted in at the MSB, so a 7-bit frame sits in [7:1].
    assign rx_word  = bit8 ? shift_q : {1'b0, shift_q[7:1]};

    always_comb begin
        state_d    = state_q;
        smp_cnt_d  = smp_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_acc_d  = par_acc_q;
        par_err_d  = par_err_q;
        frame_done = 1'b0;

        if (baud_clock) begin
            unique case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d   = START;
                        smp_cnt_d = '0;
                    end
                end
                START: begin
                    if (smp_cnt_q == START_SAMPLE) begin
                        smp_cnt_d = '0;
                        if (!rx_s) begin
                            state_d   = DATA;
                            bit_cnt_d = '0;
                            par_acc_d = 1'b0;
                            par_err_d = 1'b0;
                        end else begin
                            // Start bit not held to mid-cell: a line glitch.
                            state_d = IDLE;
                        end
                    end else begin
                        smp_cnt_d = smp_cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    // The counter wraps 15 -> 0, keeping the next bit's sample
                    // exactly one bit cell later.
                    smp_cnt_d = smp_cnt_q + 1'b1;
                    if (smp_cnt_q == MID_SAMPLE) begin
                        shift_d   = {rx_s, shift_q[7:1]};
                        par_acc_d = par_acc_q ^ rx_s;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        // >= so a mid-frame change of bit8 still terminates.
                        if (bit_cnt_q >= last_bit) begin
                            state_d = parity_en ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    smp_cnt_d = smp_cnt_q + 1'b1;
                    if (smp_cnt_q == MID_SAMPLE) begin
                        par_err_d = rx_s ^ par_acc_q ^ odd_n_even;
                        state_d   = STOP;
                    end
                end
                STOP: begin
                    smp_cnt_d = smp_cnt_q + 1'b1;
                    if (smp_cnt_q == MID_SAMPLE) begin
                        // Leave at mid stop bit so a back-to-back start edge
                        // is not missed.
                        frame_done = 1'b1;
                        state_d    = IDLE;
                        smp_cnt_d  = '0;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    smp_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            smp_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_acc_q <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            smp_cnt_q <= smp_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_acc_q <= par_acc_d;
            par_err_q <= par_err_d;
        end
    end

    // A read in the completion cycle frees the holding register first, so
    // the new frame loads instead of overflowing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_byte_q     <= '0;
            rx_ready_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            framing_err_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else if (frame_done && rx_ready_q && !read_rx_byte) begin
            overflow_q <= 1'b1;
        end else if (frame_done) begin
            rx_byte_q     <= rx_word;
            rx_ready_q    <= 1'b1;
            parity_err_q  <= par_err_q;
            framing_err_q <= ~rx_s;
            overflow_q    <= 1'b0;
        end else if (read_rx_byte && rx_ready_q) begin
            rx_ready_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            framing_err_q <= 1'b0;
            overflow_q    <= 1'b0;
        end
    end

    assign rx_byte     = rx_byte_q;
    assign rx_ready    = rx_ready_q;
    assign parity_err  = parity_err_q;
    assign framing_err = framing_err_q;
    assign overflow    = overflow_q;

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Asynchronous UART receive stage for the CoreUARTapb data path. It consumes the x16 `baud_clock` enable pulse from the UART clock generator and an asynchronous serial `rx` line. It oversamples each bit, detects and qualifies start bits, and shifts in 7 or 8 data bits LSB-first. It checks optional parity and the stop bit, then presents one received byte with ready and error flags to the receive FIFO control or APB register logic.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: number of flops in the `rx` metastability synchronizer; legal values are 2–3.

Ports:
- `clk`  in  1  system clock; all logic runs on this clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `baud_clock`  in  1  x16 baud enable, one `clk` cycle wide; all bit timing advances only on cycles where it is high.
- `rx`  in  1  serial input, asynchronous, idle high.
- `bit8`  in  1  selects 8 data bits (1) or 7 data bits (0).
- `parity_en`  in  1  enables reception of a parity bit.
- `odd_n_even`  in  1  parity sense: 1 = odd, 0 = even.
- `read_rx_byte`  in  1  single-cycle pop from the consumer; acknowledges the byte and clears the flags.
- `rx_byte`  out  8  received data; bit 7 is forced to 0 in 7-bit mode.
- `rx_ready`  out  1  a byte is held and has not yet been read.
- `parity_err`  out  1  sticky; parity of the held byte was wrong.
- `framing_err`  out  1  sticky; the stop bit was sampled low.
- `overflow`  out  1  sticky; a byte completed while `rx_ready` was still 1.

## Operation
- `rx` passes through `SYNC_STAGES` flops, each reset to 1, to produce `rx_s`. All decisions use `rx_s`.
- State machine `IDLE`, `START`, `DATA`, `PARITY`, `STOP`. The state, the 4-bit tick counter `smp_cnt` and the 3-bit bit counter `bit_cnt` change only on `baud_clock` cycles.
- `IDLE`: when `rx_s`=0 on a tick, go to `START` with `smp_cnt`=0.
- `START`: increment `smp_cnt` each tick. At `smp_cnt`=7 (mid start bit):
  - `rx_s`=0: go to `DATA`, with `smp_cnt`=0 and `bit_cnt`=0.
  - `rx_s`=1: treat as a glitch and return to `IDLE` with no flags changed.
- `DATA`: at `smp_cnt`=15 (mid bit), shift `rx_s` into the MSB of the shift register and increment `bit_cnt`. After the last bit (`bit_cnt` reaches 7 or 8 per `bit8`), go to `PARITY` if `parity_en`=1, otherwise `STOP`.
- `PARITY`: at `smp_cnt`=15, capture `rx_s`.
  - Computed parity is the XOR of the received data bits, XOR `odd_n_even`.
  - A mismatch marks the frame as a parity error.
- `STOP`: at `smp_cnt`=15, complete the frame and return to `IDLE` immediately (half a stop bit early) so back-to-back frames are accepted.
- Frame completion when `rx_ready`=0:
  - Load `rx_byte`; in 7-bit mode the byte is right-justified with bit 7 = 0.
  - Set `rx_ready`=1.
  - Set `parity_err` if the frame had a parity error.
  - Set `framing_err` if `rx_s`=0 at the stop sample.
- Frame completion when `rx_ready`=1: discard the new byte, set `overflow`=1, and leave `rx_byte`, `parity_err` and `framing_err` unchanged.
- `read_rx_byte`=1 clears `rx_ready`, `parity_err`, `framing_err` and `overflow` on the next edge. A read while `rx_ready`=0 has no effect.
- Read and completion in the same cycle: the read takes effect first, so the new byte loads, `rx_ready` stays 1, the new flags are taken from the new frame, and `overflow` is not set.
- Mode inputs (`bit8`, `parity_en`, `odd_n_even`) are sampled continuously; changing them mid-frame is undefined but must not hang the FSM, which must always reach `IDLE`.

## Timing
- Reset values:
  - `rx_byte`=0x00; `rx_ready`, `parity_err`, `framing_err`, `overflow` = 0.
  - FSM in `IDLE`; both counters 0; synchronizer flops = 1.
- Reset asserted mid-frame aborts the frame immediately with no flag set. After release, reception resumes at the next high-to-low edge on `rx_s`.
- Latency from the falling edge of the `rx` start bit:
  - `SYNC_STAGES` clk cycles, plus 1 tick to enter `START`;
  - then 8 ticks to mid start bit, plus 16 × (data bits + parity bit) + 16 ticks to mid stop bit.
  - `rx_ready` rises 1 clk cycle after that final tick.
- All outputs are registered and there are no combinational paths from inputs to outputs.
- Jitter tolerance: ±1 tick of start-edge detection uncertainty.

## Structure
- Package `uart_rx_pkg` contains:
  - the state enum `rx_state_t` (`IDLE`, `START`, `DATA`, `PARITY`, `STOP`);
  - `TICKS_PER_BIT`=16, `START_SAMPLE`=7, `MID_SAMPLE`=15.
- Sub-module `uart_rx_sync`: a parameterized `SYNC_STAGES` flop chain with reset to 1. It is reused by the CTS/RTS logic.
- Top level contains the FSM, counters, shift register, parity accumulator and output/flag registers.

## Test plan
- 8N1 byte: `baud_clock` tied high, `bit8`=1, `parity_en`=0, send 0xA5 at 16 clk/bit -> `rx_byte`=0xA5, `rx_ready`=1, no error flags, within the latency formula ±1 cycle.
- 7E1 with a bad parity bit: send 0x35 with parity=1 -> `rx_byte`=0x35 and `parity_err`=1. Repeat with `odd_n_even`=1 -> `parity_err`=0.
- Framing error: send 0x00 with stop bit low -> `framing_err`=1. After a `read_rx_byte` pulse, all flags are 0.
- Overflow: send 0x11 then 0x22 without reading -> `rx_byte`=0x11, `overflow`=1. Second case: pulse `read_rx_byte` on the exact completion cycle of 0x22 -> `rx_byte`=0x22, `overflow`=0.
- Glitch: a 4-tick low pulse on `rx` -> no `rx_ready`, FSM back in `IDLE`. Then a valid 0x5A frame is received correctly.
- Reset during the `DATA` state of a frame -> all outputs are at reset values, and the following frame 0xC3 is received correctly.
